// File: rtl/redmule_pkg.sv
// Shared RedMulE configuration types: per-slot context lifecycle and the
// default sizing of the multi-context register queue.
package redmule_pkg;

    localparam int unsigned N_CONTEXT    = 2;
    localparam int unsigned REDMULE_REGS = 24;
    localparam int unsigned CTX_ID_W     = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;

    typedef enum logic [1:0] {
        CTX_FREE   = 2'd0,
        CTX_PROG   = 2'd1,
        CTX_QUEUED = 2'd2,
        CTX_ACTIVE = 2'd3
    } ctx_state_e;

endpackage

// File: rtl/redmule_ctx_queue_if.sv
// Engine-side job dispatch handshake and completion report of the context queue.
interface redmule_ctx_queue_if #(
    parameter int unsigned ID_W   = 1,
    parameter int unsigned N_REGS = 24
);
    logic                   job_valid;
    logic                   job_ready;
    logic [ID_W-1:0]        job_id;
    logic [N_REGS*32-1:0]   job_regs;
    logic                   done;
    logic                   evt_done;
    logic [ID_W-1:0]        evt_id;

    modport master (
        output job_valid, job_id, job_regs, evt_done, evt_id,
        input  job_ready, done
    );

    modport slave (
        input  job_valid, job_id, job_regs, evt_done, evt_id,
        output job_ready, done
    );
endinterface

// File: rtl/redmule_ctx_slot.sv
// One context slot: N_REGS x 32-bit registers with byte-lane writes and
// synchronous clear, exposed as a packed vector (reg 0 at the LSBs).
module redmule_ctx_slot #(
    parameter int unsigned N_REGS = 24,
    parameter int unsigned RIDX_W = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [RIDX_W-1:0]    wr_addr_i,
    input  logic [31:0]          wr_data_i,
    input  logic [3:0]           wr_be_i,
    output logic [N_REGS*32-1:0] regs_o
);

    logic [31:0] regs_q [N_REGS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned r = 0; r < N_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wr_en_i && (32'(wr_addr_i) < N_REGS)) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wr_be_i[b]) begin
                    regs_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    for (genvar r = 0; r < N_REGS; r++) begin : g_pack
        assign regs_o[32*r +: 32] = regs_q[r];
    end

endmodule

// File: rtl/redmule_ctx_queue.sv
// Multi-context job queue: software acquires/programs/triggers slots in ring
// order, the engine consumes them FIFO and frees them on done.
module redmule_ctx_queue
    import redmule_pkg::*;
#(
    parameter int unsigned N_CONTEXT = redmule_pkg::N_CONTEXT,
    parameter int unsigned N_REGS    = REDMULE_REGS,
    parameter int unsigned ID_W      = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1,
    parameter int unsigned RIDX_W    = (N_REGS > 1) ? $clog2(N_REGS) : 1,
    localparam int unsigned CNT_W    = $clog2(N_CONTEXT + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                acquire_i,
    output logic                acquire_gnt_o,
    output logic [ID_W-1:0]     acquire_id_o,
    input  logic                wr_en_i,
    input  logic [RIDX_W-1:0]   wr_addr_i,
    input  logic [31:0]         wr_data_i,
    input  logic [3:0]          wr_be_i,
    input  logic [RIDX_W-1:0]   rd_addr_i,
    output logic [31:0]         rd_data_o,
    input  logic                trigger_i,
    output logic                trigger_err_o,
    redmule_ctx_queue_if.master job,
    output logic                busy_o,
    output logic [CNT_W-1:0]    free_cnt_o
);

    ctx_state_e           state_q [N_CONTEXT];
    ctx_state_e           state_d [N_CONTEXT];
    logic [ID_W-1:0]      sw_ptr_q, sw_ptr_d, hw_ptr_q, hw_ptr_d;
    logic [CNT_W-1:0]     free_cnt_q, free_cnt_d;
    logic                 gnt_q, gnt_d, err_q, err_d, evt_q, evt_d;
    logic [ID_W-1:0]      gnt_id_q, gnt_id_d, evt_id_q, evt_id_d;
    logic [31:0]          rd_data_q, rd_data_d;
    logic                 free_dec, free_inc;
    logic                 prog_valid, head_queued, head_active;
    logic [N_REGS*32-1:0] slot_regs [N_CONTEXT];

    function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
        return (p == ID_W'(N_CONTEXT - 1)) ? '0 : p + ID_W'(1);
    endfunction

    // Slots are allocated and retired in ring order, so the PROG slot (if any)
    // is always at sw_ptr and the ACTIVE/next-queued slot is always at hw_ptr.
    assign prog_valid  = (state_q[sw_ptr_q] == CTX_PROG);
    assign head_queued = (state_q[hw_ptr_q] == CTX_QUEUED);
    assign head_active = (state_q[hw_ptr_q] == CTX_ACTIVE);

    for (genvar k = 0; k < N_CONTEXT; k++) begin : g_slot
        redmule_ctx_slot #(
            .N_REGS (N_REGS),
            .RIDX_W (RIDX_W)
        ) u_slot (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .wr_en_i   (wr_en_i && prog_valid && (sw_ptr_q == ID_W'(k))),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .wr_be_i   (wr_be_i),
            .regs_o    (slot_regs[k])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < N_CONTEXT; i++) begin
                state_q[i] <= CTX_FREE;
            end
            sw_ptr_q   <= '0;
            hw_ptr_q   <= '0;
            free_cnt_q <= CNT_W'(N_CONTEXT);
            gnt_q      <= 1'b0;
            gnt_id_q   <= '0;
            err_q      <= 1'b0;
            evt_q      <= 1'b0;
            evt_id_q   <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            sw_ptr_q   <= sw_ptr_d;
            hw_ptr_q   <= hw_ptr_d;
            free_cnt_q <= free_cnt_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            err_q      <= err_d;
            evt_q      <= evt_d;
            evt_id_q   <= evt_id_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sw_ptr_d  = sw_ptr_q;
        hw_ptr_d  = hw_ptr_q;
        gnt_d     = 1'b0;
        gnt_id_d  = sw_ptr_q;
        err_d     = 1'b0;
        evt_d     = 1'b0;
        evt_id_d  = hw_ptr_q;
        rd_data_d = '0;
        free_dec  = 1'b0;
        free_inc  = 1'b0;

        if (prog_valid && (32'(rd_addr_i) < N_REGS)) begin
            rd_data_d = slot_regs[sw_ptr_q][{rd_addr_i, 5'b0} +: 32];
        end

        if (acquire_i) begin
            if (prog_valid) begin
                gnt_d = 1'b1;
            end else if (state_q[sw_ptr_q] == CTX_FREE) begin
                state_d[sw_ptr_q] = CTX_PROG;
                gnt_d             = 1'b1;
                free_dec          = 1'b1;
            end
        end

        if (trigger_i) begin
            if (prog_valid) begin
                state_d[sw_ptr_q] = CTX_QUEUED;
                sw_ptr_d          = ptr_inc(sw_ptr_q);
            end else begin
                err_d = 1'b1;
            end
        end

        if (head_queued && job.job_ready) begin
            state_d[hw_ptr_q] = CTX_ACTIVE;
        end

        if (job.done && head_active) begin
            state_d[hw_ptr_q] = CTX_FREE;
            hw_ptr_d          = ptr_inc(hw_ptr_q);
            evt_d             = 1'b1;
            free_inc          = 1'b1;
        end

        unique case ({free_dec, free_inc})
            2'b10:   free_cnt_d = free_cnt_q - CNT_W'(1);
            2'b01:   free_cnt_d = free_cnt_q + CNT_W'(1);
            default: free_cnt_d = free_cnt_q;
        endcase
    end

    always_comb begin
        job.job_valid = head_queued;
        job.job_id    = hw_ptr_q;
        job.job_regs  = slot_regs[hw_ptr_q];
        job.evt_done  = evt_q;
        job.evt_id    = evt_id_q;
        acquire_gnt_o = gnt_q;
        acquire_id_o  = gnt_id_q;
        trigger_err_o = err_q;
        rd_data_o     = rd_data_q;
        free_cnt_o    = free_cnt_q;
        busy_o        = (free_cnt_q != CNT_W'(N_CONTEXT));
    end

endmodule

// File: tb/tb_redmule_ctx_queue.sv
// Drives identical stimulus into a 2-slot and a 3-slot queue and checks both
// against a ring-occupancy model of the slot lifecycle.
module tb_redmule_ctx_queue;

    localparam int unsigned NR = 24;
    localparam int unsigned RW = 5;
    localparam int unsigned RB = NR * 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, acquire, wr_en, trigger, job_ready, done;
    logic [RW-1:0] wr_addr, rd_addr;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;

    redmule_ctx_queue_if #(.ID_W(1), .N_REGS(NR)) job2 ();
    redmule_ctx_queue_if #(.ID_W(2), .N_REGS(NR)) job3 ();
    assign job2.job_ready = job_ready;
    assign job2.done      = done;
    assign job3.job_ready = job_ready;
    assign job3.done      = done;

    logic        gnt2, err2, busy2, gnt3, err3, busy3;
    logic [0:0]  gid2;
    logic [1:0]  gid3, fc2, fc3;
    logic [31:0] rd2, rd3;

    redmule_ctx_queue #(.N_CONTEXT(2), .N_REGS(NR)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .acquire_i(acquire), .acquire_gnt_o(gnt2),
        .acquire_id_o(gid2), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_be_i(wr_be), .rd_addr_i(rd_addr), .rd_data_o(rd2), .trigger_i(trigger),
        .trigger_err_o(err2), .job(job2), .busy_o(busy2), .free_cnt_o(fc2)
    );

    redmule_ctx_queue #(.N_CONTEXT(3), .N_REGS(NR)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .acquire_i(acquire), .acquire_gnt_o(gnt3),
        .acquire_id_o(gid3), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_be_i(wr_be), .rd_addr_i(rd_addr), .rd_data_o(rd3), .trigger_i(trigger),
        .trigger_err_o(err3), .job(job3), .busy_o(busy3), .free_cnt_o(fc3)
    );

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [RB-1:0] got, input logic [RB-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Occupied slots always form one contiguous ring run starting at 'oldest';
    // the newest may be in programming, the oldest may be running.
    int unsigned nc [2] = '{2, 3};
    int unsigned oldest [2], n_used [2], e_gid [2], e_eid [2];
    bit          prog [2], active [2], e_gnt [2], e_err [2], e_evt [2];
    logic [31:0] e_rd [2];
    logic [31:0] mregs [2][3][NR];

    task automatic model_step();
        for (int unsigned k = 0; k < 2; k++) begin
            int unsigned n, pid, queued;
            bit acq_new, fin, disp;
            n = nc[k];
            e_gnt[k] = 0; e_err[k] = 0; e_evt[k] = 0; e_rd[k] = '0;
            if (rst) begin
                oldest[k] = 0; n_used[k] = 0; prog[k] = 0; active[k] = 0;
                for (int unsigned s = 0; s < 3; s++)
                    for (int unsigned r = 0; r < NR; r++) mregs[k][s][r] = '0;
            end else begin
                pid    = (oldest[k] + n_used[k] + n - 1) % n;
                queued = n_used[k] - 32'(prog[k]) - 32'(active[k]);
                if (prog[k] && rd_addr < NR) e_rd[k] = mregs[k][pid][rd_addr];
                if (wr_en && prog[k] && wr_addr < NR)
                    for (int unsigned b = 0; b < 4; b++)
                        if (wr_be[b]) mregs[k][pid][wr_addr][8*b +: 8] = wr_data[8*b +: 8];
                acq_new = 0;
                if (acquire) begin
                    if (prog[k]) begin
                        e_gnt[k] = 1; e_gid[k] = pid;
                    end else if (n_used[k] < n) begin
                        e_gnt[k] = 1; e_gid[k] = (oldest[k] + n_used[k]) % n; acq_new = 1;
                    end
                end
                fin  = done && active[k];
                disp = !active[k] && queued > 0 && job_ready;
                if (trigger) begin
                    if (prog[k]) prog[k] = 0;
                    else e_err[k] = 1;
                end
                if (acq_new) prog[k] = 1;
                if (disp) active[k] = 1;
                if (fin) begin
                    active[k] = 0; e_evt[k] = 1; e_eid[k] = oldest[k];
                    oldest[k] = (oldest[k] + 1) % n;
                end
                n_used[k] = n_used[k] + 32'(acq_new) - 32'(fin);
            end
        end
    endtask

    task automatic check_outputs();
        for (int unsigned k = 0; k < 2; k++) begin
            logic g_gnt, g_err, g_busy, g_valid, g_evt, e_valid;
            logic [31:0] g_gid, g_eid, g_jid, g_rd, g_fc;
            logic [RB-1:0] g_regs, e_regs;
            int unsigned queued;
            if (k == 0) begin
                g_gnt = gnt2; g_gid = 32'(gid2); g_err = err2; g_busy = busy2; g_fc = 32'(fc2);
                g_rd = rd2; g_valid = job2.job_valid; g_jid = 32'(job2.job_id);
                g_regs = job2.job_regs; g_evt = job2.evt_done; g_eid = 32'(job2.evt_id);
            end else begin
                g_gnt = gnt3; g_gid = 32'(gid3); g_err = err3; g_busy = busy3; g_fc = 32'(fc3);
                g_rd = rd3; g_valid = job3.job_valid; g_jid = 32'(job3.job_id);
                g_regs = job3.job_regs; g_evt = job3.evt_done; g_eid = 32'(job3.evt_id);
            end
            queued  = n_used[k] - 32'(prog[k]) - 32'(active[k]);
            e_valid = !active[k] && queued > 0;
            for (int unsigned r = 0; r < NR; r++) e_regs[32*r +: 32] = mregs[k][oldest[k]][r];
            check($sformatf("n%0d_gnt", nc[k]), RB'(g_gnt), RB'(e_gnt[k]));
            if (e_gnt[k]) check($sformatf("n%0d_gnt_id", nc[k]), RB'(g_gid), RB'(e_gid[k]));
            check($sformatf("n%0d_trig_err", nc[k]), RB'(g_err), RB'(e_err[k]));
            check($sformatf("n%0d_evt", nc[k]), RB'(g_evt), RB'(e_evt[k]));
            if (e_evt[k]) check($sformatf("n%0d_evt_id", nc[k]), RB'(g_eid), RB'(e_eid[k]));
            check($sformatf("n%0d_rd_data", nc[k]), RB'(g_rd), RB'(e_rd[k]));
            check($sformatf("n%0d_job_valid", nc[k]), RB'(g_valid), RB'(e_valid));
            if (e_valid) begin
                check($sformatf("n%0d_job_id", nc[k]), RB'(g_jid), RB'(oldest[k]));
                check($sformatf("n%0d_job_regs", nc[k]), g_regs, e_regs);
            end
            check($sformatf("n%0d_free_cnt", nc[k]), RB'(g_fc), RB'(nc[k] - n_used[k]));
            check($sformatf("n%0d_busy", nc[k]), RB'(g_busy), RB'(n_used[k] != 0));
        end
    endtask

    task automatic step(input bit r, input bit a, input bit we, input logic [RW-1:0] wa,
                        input logic [31:0] wd, input logic [3:0] be, input logic [RW-1:0] ra,
                        input bit t, input bit rdy, input bit d);
        rst = r; acquire = a; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_addr = ra; trigger = t; job_ready = rdy; done = d;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle();               step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic acq();                step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic trig();               step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); endtask
    task automatic dispatch();           step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); endtask
    task automatic finish_job();         step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
    task automatic wr(input logic [RW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        step(0, 0, 1, a, d, be, a, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        acq(); acq(); idle();
        wr(5'd3, 32'h0020_0010, 4'hF);
        wr(5'd3, 32'hFFFF_AAAA, 4'h3);
        step(0, 0, 0, 0, 0, 0, 5'd3, 0, 0, 0);
        step(0, 0, 1, 5'd25, 32'hDEAD_BEEF, 4'hF, 5'd25, 0, 0, 0);
        step(0, 0, 1, 5'd0, 32'h0000_ABCD, 4'hF, 5'd0, 1, 0, 0);
        trig(); idle();
        dispatch(); idle(); finish_job(); idle(); finish_job();
        // fill every slot, then try once more with the queue full
        for (int unsigned i = 0; i < 4; i++) begin
            acq(); wr(5'd0, 32'h100 + i, 4'hF); trig();
        end
        acq(); idle();
        for (int unsigned i = 0; i < 4; i++) begin
            dispatch(); step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1); trig();
        end
        // reset with one job running and another waiting
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        acq(); trig(); acq(); trig(); dispatch(); idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        finish_job(); idle();
        for (int unsigned c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 1) == 1), RW'($urandom_range(0, 27)), $urandom,
                 4'($urandom), RW'($urandom_range(0, 27)), ($urandom_range(0, 9) < 2),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/redmule_ctx_queue.md
Name: redmule_ctx_queue

Overview:
- Multi-context job queue for the RedMulE configuration path; generalises the fixed two-context register file to N_CONTEXT slots of N_REGS 32-bit registers.
- Software acquires a slot, programs it, then triggers it. Triggered slots are dispatched to the controller/scheduler in FIFO (ring) order through a valid/ready handshake.
- A slot is freed when the engine signals done, so software can program job k+1..k+N-1 while job k runs.

Parameters:
N_CONTEXT, 2, number of context slots (>=1, any integer, not required to be a power of two)
N_REGS, 24, 32-bit registers per slot
ID_W, max(1,$clog2(N_CONTEXT)), slot id width
RIDX_W, $clog2(N_REGS), register index width

Ports:
clk_i  in  1  clock
rst_i  in  1  one clock; reset is synchronous and active-high
acquire_i  in  1  request a slot for programming
acquire_gnt_o  out  1  one-cycle pulse: slot granted
acquire_id_o  out  ID_W  granted slot id, valid with acquire_gnt_o
wr_en_i  in  1  register write into the PROG slot
wr_addr_i  in  RIDX_W  register index
wr_data_i  in  32  write data
wr_be_i  in  4  byte enables
rd_addr_i  in  RIDX_W  readback index within the PROG slot
rd_data_o  out  32  registered readback data
trigger_i  in  1  commit the PROG slot to the queue
trigger_err_o  out  1  one-cycle pulse: trigger with no PROG slot
job_valid_o  out  1  head slot ready for the engine
job_ready_i  in  1  engine accepts the job
job_id_o  out  ID_W  head slot id
job_regs_o  out  N_REGS*32  head slot contents, packed, reg 0 at LSBs
done_i  in  1  engine finished the ACTIVE job
evt_done_o  out  1  one-cycle pulse: job completed
evt_id_o  out  ID_W  completed slot id
busy_o  out  1  any slot not FREE
free_cnt_o  out  $clog2(N_CONTEXT+1)  number of FREE slots

Behaviour:
- Per-slot state ctx_state_e: FREE -> PROG (acquire) -> QUEUED (trigger) -> ACTIVE (job handshake) -> FREE (done_i).
- sw_ptr selects the next slot to allocate; hw_ptr selects the head slot. Both wrap explicitly from N_CONTEXT-1 to 0. Order is strict FIFO.
- At most one slot is in PROG at any time.
- Acquire:
  - Decided on the state registered at the end of the previous cycle.
  - If slot[sw_ptr] is FREE: slot becomes PROG and acquire_gnt_o=1 with acquire_id_o=sw_ptr in the next cycle.
  - If a PROG slot already exists: re-grant the same id; idempotent; free_cnt unchanged.
  - If there is no FREE slot: acquire_gnt_o stays 0 and nothing changes; software retries.
- Write:
  - Applied to the PROG slot with byte-lane masking.
  - Dropped if there is no PROG slot or wr_addr_i >= N_REGS.
  - Slot contents are retained across free/reacquire, so software may reprogram incrementally.
- rd_data_o = PROG slot reg[rd_addr_i], registered with 1-cycle latency. It is 0 if there is no PROG slot or the index is out of range. A write and a read to the same index in one cycle returns the old value.
- Trigger:
  - PROG -> QUEUED, and sw_ptr advances.
  - Without a PROG slot: trigger_err_o pulses next cycle and nothing else changes.
  - Write and trigger in the same cycle: the write lands in the slot before it is queued.
- Dispatch:
  - job_valid_o = (slot[hw_ptr]==QUEUED) && no slot ACTIVE, from registered state. A slot triggered at cycle t is visible at t+1.
  - On job_valid_o && job_ready_i the slot becomes ACTIVE.
  - job_id_o and job_regs_o remain stable while job_valid_o is high.
- Done:
  - done_i with an ACTIVE slot: slot -> FREE, hw_ptr advances, evt_done_o=1 with evt_id_o=that id next cycle.
  - done_i with no ACTIVE slot is ignored.
- Simultaneous events:
  - done and acquire on a full queue: the freed slot is grantable only in the following cycle.
  - done and a next-queued slot: dispatch happens no earlier than the next cycle.
- free_cnt_o: resets to N_CONTEXT, -1 on a new grant, +1 on done. It never under- or overflows given the rules above.
- busy_o = free_cnt_o != N_CONTEXT.
- Reset (including mid-job):
  - All slots FREE and all registers 0; both pointers 0.
  - All pulse outputs 0; job_valid_o=0; rd_data_o=0; free_cnt_o=N_CONTEXT; busy_o=0.
  - A late done_i arriving after reset is ignored.

Decomposition:
- redmule_pkg gains:
  - ctx_state_e (2-bit: FREE, PROG, QUEUED, ACTIVE);
  - CTX_ID_W derived from N_CONTEXT.
- Defaults come from redmule_pkg: N_CONTEXT and REDMULE_REGS.
- Sub-module redmule_ctx_slot: one slot's N_REGS x 32 register array with byte-enable write and synchronous clear, instantiated N_CONTEXT times.
- All pointer, state and handshake logic stays in redmule_ctx_queue.

Test Plan:
- Reset, acquire_i one cycle -> next cycle acquire_gnt_o=1, acquire_id_o=0; free_cnt_o 2->1; busy_o=1.
- Write reg 3 = 0x00200010 with be 4'hF, then 0xFFFFAAAA with be 4'h3; rd_addr_i=3 -> rd_data_o=0x0020AAAA.
- N_CONTEXT=2:
  - Acquire+trigger twice; third acquire -> no grant.
  - job_valid_o=1, id 0; ready -> ACTIVE; done_i -> evt_done_o=1, evt_id_o=0, free_cnt_o=1.
  - Second job dispatches with id 1; the next acquire grants id 0 (wrap).
- N_CONTEXT=3, four back-to-back jobs -> dispatch and evt ids 0,1,2,0; job_regs_o matches each slot's programmed reg 0 value (0x100+id).
- Negative and same-cycle cases:
  - trigger_i with no PROG slot -> trigger_err_o=1, job_valid_o stays 0.
  - Write reg 0=0xABCD in the same cycle as trigger -> dispatched job_regs_o[31:0]=0xABCD.
- Assert rst_i while a job is ACTIVE and another is QUEUED -> busy_o=0, job_valid_o=0, free_cnt_o=N_CONTEXT; a following done_i gives evt_done_o=0.
